dist_score: RTL

- Downstream consumer of the distribution generator.
- After `calc_done`, it pulls the six per-bin deviation values one at a time with an `rd_rqst`/`data_vld` handshake.
- It forms a weighted anomaly score, compares the score to a programmable threshold, and presents the result with a valid/ack handshake to the host/control logic.
- It has its own timeout so that a stalled generator cannot hang the pipeline.

---
 rtl/dist_score_if.sv | 30 +++
 rtl/dist_score.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dist_score_if.sv
// Handshake bundle between dist_score, the distribution generator and the host.
// The slave modport is the scorer's view; master is the environment driving it.
interface dist_score_if #(
  parameter int BW      = 7,
  parameter int SCORE_W = 16
);
  logic               calc_done;
  logic               data_vld;
  logic [BW-1:0]      bin_out;
  logic [SCORE_W-1:0] threshold;
  logic               res_ack;
  logic               rd_rqst;
  logic [SCORE_W-1:0] score;
  logic               anomaly;
  logic               res_err;
  logic               res_vld;
  logic               busy;
  logic [BW-1:0]      peak_val;
  logic [2:0]         peak_idx;

  modport master (
    output calc_done, data_vld, bin_out, threshold, res_ack,
    input  rd_rqst, score, anomaly, res_err, res_vld, busy, peak_val, peak_idx
  );

  modport slave (
    input  calc_done, data_vld, bin_out, threshold, res_ack,
    output rd_rqst, score, anomaly, res_err, res_vld, busy, peak_val, peak_idx
  );
endinterface

// File: rtl/dist_score.sv
// Pulls NUM_BINS deviation values after calc_done, forms a saturating weighted score
// and flags it against a latched threshold. Define DIST_SCORE_PEAK_EN for peak tracking.
module dist_score #(
  parameter int POPSIZE  = 100,
  parameter int NUM_BINS = 6,
  parameter int SCORE_W  = 16,
  parameter int TIMEOUT  = 16
) (
  input logic        clk,
  input logic        rst,
  dist_score_if.slave bus
);
  localparam int BW   = $clog2(POPSIZE);
  localparam int KW   = $clog2(NUM_BINS);
  localparam int TW   = $clog2(TIMEOUT);
  localparam int PADW = SCORE_W + 1 - BW;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_BINS - 1);
  // The request cycle counts toward the budget, so RESULT lands TIMEOUT cycles after rd_rqst.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESULT} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [SCORE_W-1:0] acc_q, acc_d;
  logic [SCORE_W-1:0] thr_q, thr_d;
  logic               pending_q, pending_d;
  logic               rd_rqst_q, rd_rqst_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               anomaly_q, anomaly_d;
  logic               res_err_q, res_err_d;
  logic               res_vld_q, res_vld_d;
  logic               busy_q, busy_d;

  logic               start;
  logic               accept;
  logic               timed_out;
  logic [SCORE_W:0]   weighted;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] acc_sat;
  logic [SCORE_W-1:0] final_score;

  assign start     = (state_q == IDLE) && (bus.calc_done || pending_q);
  assign accept    = (state_q == WAIT) && bus.data_vld;
  assign timed_out = (state_q == WAIT) && !bus.data_vld && (tmo_q == T_LAST);

  // Weight doubles every two bins: 1,1,2,2,4,4.
  assign weighted    = {{PADW{1'b0}}, bus.bin_out} << (k_q >> 1);
  assign sum         = {1'b0, acc_q} + weighted;
  assign acc_sat     = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  assign final_score = accept ? acc_sat : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      tmo_q     <= '0;
      acc_q     <= '0;
      thr_q     <= '0;
      pending_q <= 1'b0;
      rd_rqst_q <= 1'b0;
      score_q   <= '0;
      anomaly_q <= 1'b0;
      res_err_q <= 1'b0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tmo_q     <= tmo_d;
      acc_q     <= acc_d;
      thr_q     <= thr_d;
      pending_q <= pending_d;
      rd_rqst_q <= rd_rqst_d;
      score_q   <= score_d;
      anomaly_q <= anomaly_d;
      res_err_q <= res_err_d;
      res_vld_q <= res_vld_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT: begin
        if (accept)         state_d = (k_q == K_LAST) ? RESULT : REQ;
        else if (timed_out) state_d = RESULT;
      end
      RESULT:  if (bus.res_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_d       = k_q;
    tmo_d     = tmo_q;
    acc_d     = acc_q;
    thr_d     = thr_q;
    pending_d = pending_q;
    score_d   = score_q;
    anomaly_d = anomaly_q;
    res_err_d = res_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          thr_d     = bus.threshold;
          acc_d     = '0;
          k_d       = '0;
          pending_d = 1'b0;
        end
      end
      REQ:  tmo_d = '0;
      WAIT: begin
        if (accept) begin
          acc_d = acc_sat;
          k_d   = k_q + 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESULT: if (bus.calc_done) pending_d = 1'b1;
      default: ;
    endcase
    if (state_q == WAIT && state_d == RESULT) begin
      score_d   = final_score;
      anomaly_d = final_score > thr_q;
      res_err_d = !accept;
    end
    rd_rqst_d = (state_d == REQ);
    res_vld_d = (state_d == RESULT);
    busy_d    = (state_d != IDLE);
  end

  assign bus.rd_rqst = rd_rqst_q;
  assign bus.score   = score_q;
  assign bus.anomaly = anomaly_q;
  assign bus.res_err = res_err_q;
  assign bus.res_vld = res_vld_q;
  assign bus.busy    = busy_q;

`ifdef DIST_SCORE_PEAK_EN
  logic [BW-1:0] peak_val_q, peak_val_d;
  logic [2:0]    peak_idx_q, peak_idx_d;

  // Strict compare keeps the first occurrence on ties.
  always_comb begin
    peak_val_d = peak_val_q;
    peak_idx_d = peak_idx_q;
    if (start) begin
      peak_val_d = '0;
      peak_idx_d = '0;
    end else if (accept && (bus.bin_out > peak_val_q)) begin
      peak_val_d = bus.bin_out;
      peak_idx_d = 3'(k_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_val_q <= '0;
      peak_idx_q <= '0;
    end else begin
      peak_val_q <= peak_val_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  assign bus.peak_val = peak_val_q;
  assign bus.peak_idx = peak_idx_q;
`else
  assign bus.peak_val = '0;
  assign bus.peak_idx = '0;
`endif
endmodule
